// File: rtl/etapa_decodificacion.sv
// Decode stage for the RV64 pipeline. It drives the register bank's read
// pointers and captures operands, bypassing a same-cycle writeback. It also
// builds the sign-extended immediate. A busy-bit scoreboard stalls
// read-after-write hazards until the producer writes back. Writeback traffic
// passes through combinationally to the bank's write port.
module etapa_decodificacion #(
  parameter  int N      = 32,
  parameter  int DATA_W = 64,
  localparam int PW     = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic [PW-1:0]     ptr_rd_1,
  output logic [PW-1:0]     ptr_rd_2,
  input  logic [DATA_W-1:0] data_rd_1,
  input  logic [DATA_W-1:0] data_rd_2,
  input  logic              wb_valid,
  input  logic [PW-1:0]     wb_ptr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [PW-1:0]     ptr_wr,
  output logic [DATA_W-1:0] data_wr,
  output logic              wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_imm,
  output logic [PW-1:0]     out_rd,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic              out_funct7_5,
  output logic              out_illegal
);

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_X} fmt_t;

  // Raw immediate as a signed 32-bit quantity, before widening.
  function automatic logic signed [31:0] imm32(input fmt_t f, input logic [31:0] i);
    case (f)
      FMT_I:   return {{20{i[31]}}, i[31:20]};
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   return {i[31:12], 12'b0};
      FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'sd0;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] sext(input logic signed [31:0] v);
    return DATA_W'(v);
  endfunction

  // Unused sources and x0 read as zero; a same-cycle writeback beats the bank.
  function automatic logic signed [DATA_W-1:0] pick_operand(
    input logic used, input logic [PW-1:0] rs, input logic [DATA_W-1:0] bank,
    input logic byp_v, input logic [PW-1:0] byp_ptr, input logic [DATA_W-1:0] byp_data);
    if (!used || rs == '0)          return '0;
    if (byp_v && byp_ptr == rs)     return byp_data;
    return bank;
  endfunction

  fmt_t                      fmt;
  logic [PW-1:0]             rs1, rs2, rd;
  logic                      uses_rs1, uses_rs2, writes_rd, hazard, accept;
  logic                      byp1, byp2;
  logic signed [DATA_W-1:0]  op1_d, op2_d, imm_d;
  logic [N-1:0]              busy_q, busy_d;

  logic                      vld_p1;
  logic signed [DATA_W-1:0]  op1_p1, op2_p1, imm_p1;
  logic [PW-1:0]             rd_p1;
  logic [6:0]                opcode_p1;
  logic [2:0]                funct3_p1;
  logic                      funct7_5_p1, illegal_p1;

  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];
  assign ptr_rd_1 = rs1;
  assign ptr_rd_2 = rs2;

  assign ptr_wr   = wb_ptr;
  assign data_wr  = wb_data;
  assign wr_en    = wb_valid;

  // Classify the opcode into an instruction format.
  always_comb begin
    fmt = FMT_X;
    case (instr[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                                     fmt = FMT_S;
      7'b1100011:                                     fmt = FMT_B;
      7'b0110111, 7'b0010111:                         fmt = FMT_U;
      7'b1101111:                                     fmt = FMT_J;
      7'b0110011, 7'b0111011:                         fmt = FMT_R;
      default:                                        fmt = FMT_X;
    endcase
  end

  assign uses_rs1  = (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
  assign uses_rs2  = (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
  assign writes_rd = ((fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J) || (fmt == FMT_R))
                     && (rd != '0);

  // A pending writeback to the very register we wait on clears the hazard now.
  assign byp1   = wb_valid && (wb_ptr == rs1);
  assign byp2   = wb_valid && (wb_ptr == rs2);
  assign hazard = (uses_rs1 && busy_q[rs1] && !byp1) || (uses_rs2 && busy_q[rs2] && !byp2);

  assign in_ready = (!vld_p1 || out_ready) && !(in_valid && hazard) && !rst;
  assign accept   = in_valid && in_ready;

  assign op1_d = pick_operand(uses_rs1, rs1, data_rd_1, wb_valid, wb_ptr, wb_data);
  assign op2_d = pick_operand(uses_rs2, rs2, data_rd_2, wb_valid, wb_ptr, wb_data);
  assign imm_d = sext(imm32(fmt, instr));

  // Scoreboard update: clear on writeback, then set on accept so set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid)             busy_d[wb_ptr] = 1'b0;
    if (accept && writes_rd)  busy_d[rd]     = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // ---- stage p1: decoded instruction held for execute ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      op1_p1      <= '0;
      op2_p1      <= '0;
      imm_p1      <= '0;
      rd_p1       <= '0;
      opcode_p1   <= '0;
      funct3_p1   <= '0;
      funct7_5_p1 <= 1'b0;
      illegal_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1      <= 1'b1;
      op1_p1      <= op1_d;
      op2_p1      <= op2_d;
      imm_p1      <= imm_d;
      rd_p1       <= writes_rd ? rd : '0;
      opcode_p1   <= instr[6:0];
      funct3_p1   <= instr[14:12];
      funct7_5_p1 <= instr[30];
      illegal_p1  <= (fmt == FMT_X);
    end else if (out_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign out_valid    = vld_p1;
  assign out_op1      = op1_p1;
  assign out_op2      = op2_p1;
  assign out_imm      = imm_p1;
  assign out_rd       = rd_p1;
  assign out_opcode   = opcode_p1;
  assign out_funct3   = funct3_p1;
  assign out_funct7_5 = funct7_5_p1;
  assign out_illegal  = illegal_p1;

endmodule

// File: tb/tb_etapa_decodificacion.sv
// Bench for the decode stage: a small register bank, directed scenarios and
// a randomized run against a format-level reference model.
module tb_etapa_decodificacion;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_valid, wr_en, out_valid, out_ready;
  logic        out_funct7_5, out_illegal, bank_init;
  logic [31:0] instr;
  logic [4:0]  ptr_rd_1, ptr_rd_2, wb_ptr, ptr_wr, out_rd;
  logic [63:0] data_rd_1, data_rd_2, wb_data, data_wr, out_op1, out_op2, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [63:0] regs [32];
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] ADDI = 32'hFFF00093;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SW   = 32'h0020A423;
  localparam logic [31:0] ILL  = 32'h0020807F;

  always #5 clk = ~clk;

  etapa_decodificacion dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .ptr_rd_1(ptr_rd_1), .ptr_rd_2(ptr_rd_2), .data_rd_1(data_rd_1), .data_rd_2(data_rd_2),
    .wb_valid(wb_valid), .wb_ptr(wb_ptr), .wb_data(wb_data),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7_5(out_funct7_5), .out_illegal(out_illegal)
  );

  // Register bank: combinational read, write on the edge after wr_en.
  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
    end else if (wr_en && ptr_wr != 5'd0) begin
      regs[ptr_wr] <= data_wr;
    end
  end
  assign data_rd_1 = regs[ptr_rd_1];
  assign data_rd_2 = regs[ptr_rd_2];

  // Reference decode: 0=I 1=S 2=B 3=U 4=J 5=R 6=illegal
  function automatic int fmt_of(input logic [6:0] op);
    case (op)
      7'h13, 7'h1B, 7'h03, 7'h67: return 0;
      7'h23:                      return 1;
      7'h63:                      return 2;
      7'h37, 7'h17:               return 3;
      7'h6F:                      return 4;
      7'h33, 7'h3B:               return 5;
      default:                    return 6;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] i);
    logic signed [63:0] t;
    case (fmt_of(i[6:0]))
      0: t = $signed(i[31:20]);
      1: t = $signed({i[31:25], i[11:7]});
      2: begin t = $signed({i[31], i[7], i[30:25], i[11:8]}); t = t * 2; end
      3: begin t = $signed(i[31:12]); t = t * 4096; end
      4: begin t = $signed({i[31], i[19:12], i[20], i[30:21]}); t = t * 2; end
      default: t = 0;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 11)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; bank_init = 1'b1; in_valid = 1'b1; instr = ADDI; out_ready = 1'b1;
    wb_valid = 1'b0; wb_ptr = 5'd0; wb_data = 64'd0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    end
    @(negedge clk); rst = 1'b0; bank_init = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if ({out_op1, out_op2, out_imm, out_rd, out_opcode, out_funct3, out_funct7_5, out_illegal} !== '0) begin
      errors++; $display("FAIL rst_outputs got op1=%h op2=%h imm=%h rd=%0d want all 0", out_op1, out_op2, out_imm, out_rd);
    end
    checks++; if (dut.busy_q !== 32'd0) begin errors++; $display("FAIL rst_busy got %h want 0", dut.busy_q); end
  endtask

  task automatic test_addi();
    @(negedge clk); wb_valid = 1'b1; wb_ptr = 5'd2; wb_data = 64'd7;
    @(negedge clk); wb_valid = 1'b0; in_valid = 1'b1; instr = ADDI; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
    checks++; if (out_imm !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffffffffffff", out_imm); end
    checks++; if (out_op1 !== 64'd0) begin errors++; $display("FAIL addi_op1 got %h want 0", out_op1); end
    checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d want 1", out_rd); end
    checks++; if (dut.busy_q !== 32'h2) begin errors++; $display("FAIL addi_busy got %h want 2", dut.busy_q); end
  endtask

  task automatic test_raw_bypass();
    @(negedge clk); instr = ADD; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall cycle %0d got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    wb_valid = 1'b1; wb_ptr = 5'd1; wb_data = 64'h10; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_op1 !== 64'h10) begin errors++; $display("FAIL raw_op1 got %h want 10", out_op1); end
    checks++; if (out_op2 !== 64'd7) begin errors++; $display("FAIL raw_op2 got %h want 7", out_op2); end
    checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL raw_rd got %0d want 3", out_rd); end
    checks++; if (dut.busy_q !== 32'h8) begin errors++; $display("FAIL raw_busy got %h want 8", dut.busy_q); end
    @(negedge clk); in_valid = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic test_store_hold();
    wb_valid = 1'b1; wb_ptr = 5'd3; wb_data = 64'h33; in_valid = 1'b1; instr = SW; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sw_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_imm !== 64'd8) begin errors++; $display("FAIL sw_imm got %h want 8", out_imm); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL sw_rd got %0d want 0", out_rd); end
    checks++; if (out_op1 !== 64'h10 || out_op2 !== 64'd7) begin errors++; $display("FAIL sw_ops got %h %h want 10 7", out_op1, out_op2); end
    checks++; if (dut.busy_q !== 32'd0) begin errors++; $display("FAIL sw_busy got %h want 0", dut.busy_q); end
    @(negedge clk); wb_valid = 1'b0; out_ready = 1'b0; instr = ADDI;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cycle %0d got %b want 0", c, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_imm !== 64'd8 || out_op1 !== 64'h10 || out_opcode !== 7'h23) begin
        errors++; $display("FAIL hold_stable cycle %0d got v=%b imm=%h op1=%h opc=%h want 1 8 10 23", c, out_valid, out_imm, out_op1, out_opcode);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_rd !== 5'd1 || out_imm !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL hold_next got rd=%0d imm=%h want 1 all-ones", out_rd, out_imm); end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; instr = ILL; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_no_stall got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", out_illegal); end
    checks++; if (out_imm !== 64'd0 || out_op1 !== 64'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL ill_fields got imm=%h op1=%h rd=%0d want 0", out_imm, out_op1, out_rd); end
    checks++; if (dut.busy_q !== 32'h2) begin errors++; $display("FAIL ill_busy got %h want 2", dut.busy_q); end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk); instr = ADD; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rms_stall got %b want 0", in_ready); end
    @(posedge clk); #2; rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rms_valid got %b want 0", out_valid); end
    checks++; if (dut.busy_q !== 32'd0) begin errors++; $display("FAIL rms_busy got %h want 0", dut.busy_q); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rms_accept got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 64'h10 || out_op2 !== 64'd7 || out_rd !== 5'd3) begin
      errors++; $display("FAIL rms_out got v=%b op1=%h op2=%h rd=%0d want 1 10 7 3", out_valid, out_op1, out_op2, out_rd);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] mbusy;
    logic        e_vld, e_ill, e_f7, e_rdy, acc, u1, u2, wr, haz;
    logic [63:0] e_op1, e_op2, e_imm, n_op1, n_op2;
    logic [4:0]  e_rd, rs1, rs2, rd;
    logic [6:0]  e_opc;
    logic [2:0]  e_f3;
    int          f;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mbusy = '0; e_vld = 0; e_ill = 0; e_f7 = 0; e_op1 = 0; e_op2 = 0; e_imm = 0; e_rd = 0; e_opc = 0; e_f3 = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_ptr    = 5'($urandom_range(0, 7));
      wb_data   = {$urandom, $urandom};
      #1;
      f   = fmt_of(instr[6:0]);
      rs1 = instr[19:15]; rs2 = instr[24:20]; rd = instr[11:7];
      u1  = (f == 0 || f == 1 || f == 2 || f == 5);
      u2  = (f == 1 || f == 2 || f == 5);
      wr  = (f == 0 || f == 3 || f == 4 || f == 5) && rd != 0;
      haz = (u1 && mbusy[rs1] && !(wb_valid && wb_ptr == rs1)) ||
            (u2 && mbusy[rs2] && !(wb_valid && wb_ptr == rs2));
      e_rdy = (!e_vld || out_ready) && !(in_valid && haz);
      acc   = in_valid && e_rdy;
      n_op1 = (!u1 || rs1 == 0) ? 64'd0 : (wb_valid && wb_ptr == rs1) ? wb_data : regs[rs1];
      n_op2 = (!u2 || rs2 == 0) ? 64'd0 : (wb_valid && wb_ptr == rs2) ? wb_data : regs[rs2];
      checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, in_ready, e_rdy); end
      checks++;
      if (wr_en !== wb_valid || ptr_wr !== wb_ptr || data_wr !== wb_data) begin
        errors++; $display("FAIL rnd_wb_pass c=%0d got %b %0d %h want %b %0d %h", c, wr_en, ptr_wr, data_wr, wb_valid, wb_ptr, wb_data);
      end
      @(posedge clk); #1;
      if (wb_valid) mbusy[wb_ptr] = 1'b0;
      if (acc && wr) mbusy[rd] = 1'b1;
      mbusy[0] = 1'b0;
      if (acc) begin
        e_vld = 1; e_op1 = n_op1; e_op2 = n_op2; e_imm = ref_imm(instr); e_rd = wr ? rd : 5'd0;
        e_opc = instr[6:0]; e_f3 = instr[14:12]; e_f7 = instr[30]; e_ill = (f == 6);
      end else if (out_ready) begin
        e_vld = 0;
      end
      checks++; if (out_valid !== e_vld) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, e_vld); end
      checks++;
      if (out_op1 !== e_op1 || out_op2 !== e_op2 || out_imm !== e_imm) begin
        errors++; $display("FAIL rnd_data c=%0d got %h %h %h want %h %h %h", c, out_op1, out_op2, out_imm, e_op1, e_op2, e_imm);
      end
      checks++;
      if (out_rd !== e_rd || out_opcode !== e_opc || out_funct3 !== e_f3 || out_funct7_5 !== e_f7 || out_illegal !== e_ill) begin
        errors++; $display("FAIL rnd_ctrl c=%0d got %0d %h %0d %b %b want %0d %h %0d %b %b", c,
                           out_rd, out_opcode, out_funct3, out_funct7_5, out_illegal, e_rd, e_opc, e_f3, e_f7, e_ill);
      end
      checks++; if (dut.busy_q !== mbusy) begin errors++; $display("FAIL rnd_busy c=%0d got %h want %h", c, dut.busy_q, mbusy); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw_bypass();
    test_store_hold();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/etapa_decodificacion.md
# etapa_decodificacion

Instruction decode stage for the RV64 pipeline, sitting directly upstream of the 32×64 register bank. Accepts a 32-bit instruction over a valid/ready handshake and drives the bank's read pointers. It captures the operands, bypassing a same-cycle writeback, and generates the sign-extended immediate. A busy-bit scoreboard stalls read-after-write hazards. Writeback traffic passes through this stage to the bank's write port.

## Interface
- N, 32, number of architectural registers
- Bits, 64, register/operand width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts instruction this cycle
- instr  in  32  instruction word
- ptr_rd_1, ptr_rd_2  out  $clog2(N)  bank read pointers: combinational instr[19:15], instr[24:20]
- data_rd_1, data_rd_2  in  Bits  bank read data, combinational from the pointers
- wb_valid  in  1  writeback request
- wb_ptr  in  $clog2(N)  writeback destination
- wb_data  in  Bits  writeback value
- ptr_wr, data_wr, wr_en  out  $clog2(N), Bits, 1  bank write port: combinational wb_ptr, wb_data, wb_valid
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute accepts
- out_op1, out_op2, out_imm  out  Bits  operands and sign-extended immediate
- out_rd  out  $clog2(N)  destination (0 if no write)
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7_5  out  1  instr[30]
- out_illegal  out  1  unrecognised opcode

## Operation
- Format by opcode:
  - I: 0010011, 0011011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R: 0110011, 0111011
  - Any other opcode: illegal.
- Immediate, sign-extended to Bits:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R and illegal: 0
- Source use:
  - uses_rs1: every legal format except U and J.
  - uses_rs2: R, S, B.
- Destination:
  - writes_rd: I, U, J, R, when rd≠0.
  - out_rd = rd if writes_rd, else 0.
- Operand select, per source:
  - If wb_valid, wb_ptr == rs and rs ≠ 0: use wb_data (bypass).
  - Else: use data_rd_x.
  - x0 always yields 0.
  - An unused source yields 0.
- Scoreboard: busy[N-1:0], busy[0] hard-wired 0.
  - Set busy[rd] on accept when writes_rd.
  - Clear busy[wb_ptr] when wb_valid.
  - Set and clear on the same index in the same cycle: set wins.
- Hazard: (uses_rs1 & busy[rs1] & !(wb_valid & wb_ptr==rs1)), or the same term for rs2.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !(in_valid & hazard) & !rst.
  - Accept = in_valid & in_ready.
- Output register:
  - On accept: load all out_* and set out_valid.
  - Else if out_ready: clear out_valid.
  - Else: hold all out_* unchanged.
- Illegal instruction: passes with out_illegal=1, sets no busy bit, never stalls.

## Timing
- Reset (asynchronous, immediate):
  - out_valid=0, all out_* = 0, busy=0.
  - in_ready=0 while rst=1.
  - An in-flight instruction is dropped. Writeback outputs stay combinational pass-through.
- Latency: accept at edge k gives out_valid=1 after edge k.
- Throughput: 1 instruction/cycle with no hazard and out_ready=1.
- Output stall: out_ready=0 freezes out_* and forces in_ready=0; nothing is lost or duplicated.
- Hazard stall: in_ready=0 until the producing wb_valid arrives. The instruction is accepted in the same cycle as that writeback, with the bypassed value.
- Bank write occurs at the edge after wb_valid. Operands captured on that edge come from the bypass, never from stale bank data.
- Back-to-back dependent instruction (producer still in execute): stalls; no forwarding from execute in this block.
- wb_ptr=0 with wb_valid=1: passed to the bank, no bypass, no scoreboard effect.

## Test plan
- Reset held 2 cycles, then released:
  - out_valid=0, in_ready=0 during reset.
  - All out_*=0, busy=0 afterwards.
- addi x1,x0,-1 (0xFFF00093), out_ready=1:
  - out_valid after 1 cycle.
  - out_imm=0xFFFFFFFFFFFFFFFF, out_op1=0, out_rd=1, busy[1]=1.
- Then add x3,x1,x2 (0x002081B3), x2 preloaded 7:
  - in_ready=0 until wb_valid with wb_ptr=1, wb_data=0x10.
  - Accept in that cycle: out_op1=0x10, out_op2=7.
  - busy[1]=0, busy[3]=1.
- sw x2,8(x1) (0x0020A423), no busy regs:
  - out_imm=8, out_rd=0, busy unchanged.
  - Hold out_ready=0 for 3 cycles: outputs stable, in_ready=0.
- Opcode 0x7F:
  - out_illegal=1, out_imm=0, no stall, busy unchanged.
- Assert rst mid-stall (after the busy[1] set):
  - out_valid=0 and busy=0 immediately.
  - After release, add 0x002081B3 is accepted without stall.
